regfile_wb_stage: RTL and testbench
===================================

Name: regfile_wb_stage

Overview:
- Parametrised register-file block for the single-cycle/early-pipeline CPU.
- Holds the architectural GPRs and extracts rs/rt/rd and the immediate from the instruction word.
- Adds a registered write-back stage: write data and destination are selected and latched, then committed one cycle later.
- Provides read bypass from the pending write-back and a load-use scoreboard that raises a hazard flag toward the controller.

Parameters:
- DATA_W, 32: register and datapath width in bits.
- ADDR_W, 5: register index width; NUM_REGS = 2**ADDR_W.
- SP_IDX, 29: stack-pointer register index, initialised on reset.
- SP_INIT, 32'h0000_7FFC: stack-pointer reset value, truncated/zero-padded to DATA_W.
- RA_IDX, 31: link register written by JAL.
- BYPASS, 1: 1 = read ports forward pending write-back data; 0 = array value only.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserts immediately, releases synchronously to clock).
- instruction  in  32  current instruction word.
- reg_write  in  1  write-back request this cycle.
- jal  in  1  destination RA_IDX, data pc_plus4.
- reg_dst  in  1  1 = destination rd [15:11]; 0 = rt [20:16].
- mem_to_reg  in  1  1 = data from mem_data; 0 = data from alu_result.
- alu_result  in  DATA_W  ALU result.
- mem_data  in  DATA_W  memory/IO read data.
- pc_plus4  in  DATA_W  link value for JAL.
- zero_ext  in  1  1 = zero-extend imm16; 0 = sign-extend imm16.
- ld_issue  in  1  a load is issued this cycle, destination ld_dest.
- ld_dest  in  ADDR_W  destination of the issued load.
- read_data_1  out  DATA_W  GPR[rs], with bypass.
- read_data_2  out  DATA_W  GPR[rt], with bypass.
- imm_ext  out  DATA_W  extended immediate.
- hazard  out  1  rs or rt is the destination of an outstanding load.
- wb_valid  out  1  write-back stage holds a pending write.
- wb_addr  out  ADDR_W  pending write destination.
- wb_data  out  DATA_W  pending write data.

Behaviour:
Reset (reset low), asynchronous:
- All GPRs clear to 0; GPR[SP_IDX] is set to SP_INIT.
- wb_valid, wb_addr and wb_data clear to 0.
- All scoreboard busy bits clear.
- A write-back pending when reset asserts is discarded, never committed.

Write-back capture, posedge N:
- wb_valid <= reg_write.
- wb_addr <= jal ? RA_IDX : (reg_dst ? rd : rt).
- wb_data priority: jal ? pc_plus4 : mem_to_reg ? mem_data : alu_result.

Commit, posedge N+1:
- If wb_valid and wb_addr != 0: GPR[wb_addr] <= wb_data.
- Total latency from request to architectural state is 2 edges.
- Capture and commit of different requests on the same edge are independent. Back-to-back writes are supported at 1 per cycle.

Reads (combinational):
- Index 0 always returns 0.
- If BYPASS=1, wb_valid and wb_addr == index != 0: return wb_data.
- Otherwise return GPR[index].
- With BYPASS=0, a read in the commit-pending cycle returns the old value.

Immediate:
- imm_ext = zero_ext ? zero-extended imm16 : sign-extended imm16, to DATA_W.

Scoreboard (NUM_REGS busy bits, bit 0 tied to 0):
- Set at posedge when ld_issue and ld_dest != 0.
- Clear at posedge when reg_write && mem_to_reg && !jal and the captured destination matches.
- Set and clear on the same register in the same edge: set wins.
- hazard = busy[rs] | busy[rt], combinational; index 0 never hazards.

Widths and boundaries:
- DATA_W < 16: imm_ext is truncated to DATA_W.
- Writes to register 0 are dropped but still occupy the stage (wb_valid = 1).

Decomposition:
- Shared package (extend the existing defines): instruction field bit positions, RA_IDX, SP_IDX and SP_START_ADDR constants.
- Sub-module load_scoreboard: busy vector, set/clear, hazard lookup for two read indices, parametrised by ADDR_W.

Test Plan:
1. Reset release -> every read returns 0 except rs=29 -> 32'h0000_7FFC; wb_valid=0; hazard=0.
2. reg_write, reg_dst=1, rd=8, alu_result=32'hDEAD_BEEF at edge N; rs=8 in cycle N+1:
   - BYPASS=1 -> read_data_1 = DEAD_BEEF.
   - BYPASS=0 -> read_data_1 = 0.
   - After edge N+1 -> 32'hDEAD_BEEF in both modes.
3. jal=1, pc_plus4=32'h0040_0010 -> wb_addr=31; GPR31 = 0x0040_0010 after the commit edge; rd/rt ignored.
4. Write 32'h1234 to register 0 -> wb_valid=1; the read of reg 0 stays 0 with and without bypass.
5. Load-use:
   - ld_issue, ld_dest=9 -> busy[9] set; hazard=1 while rs=9.
   - Write-back with mem_to_reg=1, rt=9 -> hazard=0 after that edge.
   - Simultaneous new ld_issue to 9 on the clear edge -> hazard stays 1.
6. Reset asserted mid-cycle with wb_valid=1, wb_addr=5 -> GPR5 remains 0 after reset release; busy bits cleared.
7. Immediate extension with imm16=16'h8001 -> zero_ext=0 gives 32'hFFFF_8001; zero_ext=1 gives 32'h0000_8001.

Source files
------------

// File: rtl/regfile_wb_stage_pkg.sv
// Shared constants for the register-file / write-back block: instruction
// field positions, architectural register indices and reset values.
package regfile_wb_stage_pkg;

  // Instruction field positions (MIPS-style encoding)
  localparam int RS_LSB      = 21;
  localparam int RT_LSB      = 16;
  localparam int RD_LSB      = 11;
  localparam int IMM_LSB     = 0;
  localparam int IMM_W       = 16;
  localparam int REG_FIELD_W = 5;
  localparam int OPC_LSB     = 26;

  // Architectural register indices
  localparam int RA_IDX = 31;
  localparam int SP_IDX = 29;

  // Stack-pointer value loaded on reset
  localparam logic [31:0] SP_START_ADDR = 32'h0000_7FFC;

endpackage

// File: rtl/regfile_wb_stage_if.sv
// Bus between the CPU datapath/controller (master) and the register file (slave).
interface regfile_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic [31:0]       instruction;
  logic              reg_write;
  logic              jal;
  logic              reg_dst;
  logic              mem_to_reg;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] pc_plus4;
  logic              zero_ext;
  logic              ld_issue;
  logic [ADDR_W-1:0] ld_dest;

  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic [DATA_W-1:0] imm_ext;
  logic              hazard;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output instruction, reg_write, jal, reg_dst, mem_to_reg,
           alu_result, mem_data, pc_plus4, zero_ext, ld_issue, ld_dest,
    input  read_data_1, read_data_2, imm_ext, hazard,
           wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  instruction, reg_write, jal, reg_dst, mem_to_reg,
           alu_result, mem_data, pc_plus4, zero_ext, ld_issue, ld_dest,
    output read_data_1, read_data_2, imm_ext, hazard,
           wb_valid, wb_addr, wb_data
  );

endinterface

// File: rtl/regfile_wb_stage_load_scoreboard.sv
// Load-use scoreboard: one busy bit per GPR, set when a load issues and
// cleared when that load's write-back is captured. Register 0 never goes busy.
module regfile_wb_stage_load_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              hazard
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Next busy vector: clear first so a same-edge set on the same register wins
  always_comb begin
    // NOTE: start from the held value so every path assigns busy_next; otherwise a latch is inferred.
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (set_en) busy_next[set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Busy register
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) busy <= '0;
    else        busy <= busy_next;
  end

  assign hazard = busy[rd_addr_a] | busy[rd_addr_b];

endmodule

// File: rtl/regfile_wb_stage.sv
// Register file with a registered write-back stage, optional read bypass
// from the pending write, immediate extension and load-use hazard detection.
module regfile_wb_stage #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 5,
  parameter int          SP_IDX  = regfile_wb_stage_pkg::SP_IDX,
  parameter logic [31:0] SP_INIT = regfile_wb_stage_pkg::SP_START_ADDR,
  parameter int          RA_IDX  = regfile_wb_stage_pkg::RA_IDX,
  parameter bit          BYPASS  = 1'b1
) (
  input logic                     clock,
  input logic                     reset,
  regfile_wb_stage_if.slave       bus
);

  import regfile_wb_stage_pkg::*;

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] SP_VAL   = DATA_W'(SP_INIT);
  localparam int                EXT_W    = (DATA_W > IMM_W) ? DATA_W : IMM_W;

  // Instruction fields
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [IMM_W-1:0]  imm16;
  logic              unused_opcode;

  assign rs    = ADDR_W'(bus.instruction[RS_LSB +: REG_FIELD_W]);
  assign rt    = ADDR_W'(bus.instruction[RT_LSB +: REG_FIELD_W]);
  assign rd    = ADDR_W'(bus.instruction[RD_LSB +: REG_FIELD_W]);
  assign imm16 = bus.instruction[IMM_LSB +: IMM_W];
  assign unused_opcode = ^bus.instruction[31:OPC_LSB];

  logic [DATA_W-1:0] gpr [NUM_REGS];
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_addr_next;
  logic [DATA_W-1:0] wb_data_next;

  // Destination and data selection for the write-back capture
  always_comb begin
    wb_addr_next = rd;
    wb_data_next = bus.alu_result;
    if (bus.jal) begin
      wb_addr_next = ADDR_W'(RA_IDX);
      wb_data_next = bus.pc_plus4;
    end else begin
      wb_addr_next = bus.reg_dst ? rd : rt;
      wb_data_next = bus.mem_to_reg ? bus.mem_data : bus.alu_result;
    end
  end

  // Write-back stage register; a pending write is dropped on reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= bus.reg_write;
      wb_addr  <= wb_addr_next;
      wb_data  <= wb_data_next;
    end
  end

  // GPR array: commit the pending write; register 0 is never written
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the architectural state must be known after reset (SP preset), so this array is reset and maps to flops, not RAM.
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr[i] <= (i == SP_IDX) ? SP_VAL : '0;
      end
    end else if (wb_valid && (wb_addr != '0)) begin
      gpr[wb_addr] <= wb_data;
    end
  end

  // Read port 1 with optional bypass from the pending write
  always_comb begin
    bus.read_data_1 = gpr[rs];
    if (rs == '0)                                 bus.read_data_1 = '0;
    else if (BYPASS && wb_valid && wb_addr == rs) bus.read_data_1 = wb_data;
  end

  // Read port 2 with optional bypass from the pending write
  always_comb begin
    bus.read_data_2 = gpr[rt];
    if (rt == '0)                                 bus.read_data_2 = '0;
    else if (BYPASS && wb_valid && wb_addr == rt) bus.read_data_2 = wb_data;
  end

  // Immediate extension, truncated when the datapath is narrower than 16 bits
  logic [EXT_W-1:0] imm_wide;
  always_comb begin
    imm_wide = bus.zero_ext ? EXT_W'(imm16) : EXT_W'(signed'(imm16));
  end
  assign bus.imm_ext = imm_wide[DATA_W-1:0];

  // A captured load write-back releases the loaded register
  regfile_wb_stage_load_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_load_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .set_en    (bus.ld_issue),
    .set_addr  (bus.ld_dest),
    .clr_en    (bus.reg_write && bus.mem_to_reg && !bus.jal),
    .clr_addr  (wb_addr_next),
    .rd_addr_a (rs),
    .rd_addr_b (rt),
    .hazard    (bus.hazard)
  );

  assign bus.wb_valid = wb_valid;
  assign bus.wb_addr  = wb_addr;
  assign bus.wb_data  = wb_data;

endmodule

// File: tb/tb_regfile_wb_stage.sv
// Directed bench: a bypassing and a non-bypassing instance see identical stimulus.
module tb_regfile_wb_stage;

  logic        clock;
  logic        reset;
  logic [31:0] instruction;
  logic        reg_write, jal, reg_dst, mem_to_reg, zero_ext, ld_issue;
  logic [31:0] alu_result, mem_data, pc_plus4;
  logic [4:0]  ld_dest;

  int checks   = 0;
  int failures = 0;

  regfile_wb_stage_if #(.DATA_W(32), .ADDR_W(5)) ifc_b ();
  regfile_wb_stage_if #(.DATA_W(32), .ADDR_W(5)) ifc_n ();

  assign ifc_b.instruction = instruction;
  assign ifc_b.reg_write   = reg_write;
  assign ifc_b.jal         = jal;
  assign ifc_b.reg_dst     = reg_dst;
  assign ifc_b.mem_to_reg  = mem_to_reg;
  assign ifc_b.alu_result  = alu_result;
  assign ifc_b.mem_data    = mem_data;
  assign ifc_b.pc_plus4    = pc_plus4;
  assign ifc_b.zero_ext    = zero_ext;
  assign ifc_b.ld_issue    = ld_issue;
  assign ifc_b.ld_dest     = ld_dest;

  assign ifc_n.instruction = instruction;
  assign ifc_n.reg_write   = reg_write;
  assign ifc_n.jal         = jal;
  assign ifc_n.reg_dst     = reg_dst;
  assign ifc_n.mem_to_reg  = mem_to_reg;
  assign ifc_n.alu_result  = alu_result;
  assign ifc_n.mem_data    = mem_data;
  assign ifc_n.pc_plus4    = pc_plus4;
  assign ifc_n.zero_ext    = zero_ext;
  assign ifc_n.ld_issue    = ld_issue;
  assign ifc_n.ld_dest     = ld_dest;

  regfile_wb_stage #(.BYPASS(1'b1)) u_byp (
    .clock (clock),
    .reset (reset),
    .bus   (ifc_b.slave)
  );

  regfile_wb_stage #(.BYPASS(1'b0)) u_nobyp (
    .clock (clock),
    .reset (reset),
    .bus   (ifc_n.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 11'h000};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    instruction = '0;
    reg_write   = 1'b0;
    jal         = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    zero_ext    = 1'b0;
    ld_issue    = 1'b0;
    ld_dest     = '0;
    alu_result  = '0;
    mem_data    = '0;
    pc_plus4    = '0;
    #12 reset = 1'b1;
    tick();

    // Reset state
    instruction = mk(29, 0, 0);
    #1;
    check("rst_sp_byp", ifc_b.read_data_1, 32'h0000_7FFC);
    check("rst_sp_nobyp", ifc_n.read_data_1, 32'h0000_7FFC);
    check("rst_r0", ifc_b.read_data_2, 32'h0);
    instruction = mk(31, 8, 0);
    #1;
    check("rst_r31", ifc_b.read_data_1, 32'h0);
    check("rst_r8", ifc_n.read_data_2, 32'h0);
    check("rst_wb_valid", ifc_b.wb_valid, 32'h0);
    check("rst_hazard", ifc_b.hazard, 32'h0);

    // ALU write to rd=8, bypass visible only in the bypassing instance
    instruction = mk(0, 0, 8);
    reg_write = 1'b1; reg_dst = 1'b1; alu_result = 32'hDEAD_BEEF;
    tick();
    reg_write = 1'b0; reg_dst = 1'b0; alu_result = '0;
    instruction = mk(8, 0, 0);
    #1;
    check("wr8_bypass", ifc_b.read_data_1, 32'hDEAD_BEEF);
    check("wr8_nobypass_old", ifc_n.read_data_1, 32'h0);
    check("wr8_wb_addr", ifc_b.wb_addr, 32'd8);
    check("wr8_wb_valid", ifc_n.wb_valid, 32'h1);
    tick();
    check("wr8_commit_byp", ifc_b.read_data_1, 32'hDEAD_BEEF);
    check("wr8_commit_nobyp", ifc_n.read_data_1, 32'hDEAD_BEEF);
    check("wr8_wb_idle", ifc_b.wb_valid, 32'h0);

    // JAL: destination forced to 31 with pc_plus4, rd/rt/alu ignored
    instruction = mk(0, 8, 8);
    jal = 1'b1; reg_write = 1'b1; reg_dst = 1'b1;
    pc_plus4 = 32'h0040_0010; alu_result = 32'h1111_1111;
    tick();
    jal = 1'b0; reg_write = 1'b0; reg_dst = 1'b0;
    instruction = mk(31, 8, 0);
    #1;
    check("jal_wb_addr", ifc_b.wb_addr, 32'd31);
    check("jal_wb_data", ifc_b.wb_data, 32'h0040_0010);
    check("jal_nobyp_old", ifc_n.read_data_1, 32'h0);
    tick();
    check("jal_commit_byp", ifc_b.read_data_1, 32'h0040_0010);
    check("jal_commit_nobyp", ifc_n.read_data_1, 32'h0040_0010);
    check("jal_r8_untouched", ifc_n.read_data_2, 32'hDEAD_BEEF);

    // Write to register 0 occupies the stage but never reads back
    instruction = mk(0, 0, 0);
    reg_write = 1'b1; reg_dst = 1'b1; alu_result = 32'h0000_1234;
    tick();
    reg_write = 1'b0; reg_dst = 1'b0;
    #1;
    check("r0_wb_valid", ifc_b.wb_valid, 32'h1);
    check("r0_wb_addr", ifc_b.wb_addr, 32'd0);
    check("r0_read_byp", ifc_b.read_data_1, 32'h0);
    check("r0_read_nobyp", ifc_n.read_data_1, 32'h0);
    tick();
    check("r0_after_commit", ifc_b.read_data_1, 32'h0);

    // Back-to-back writes to r10 then r11
    instruction = mk(0, 0, 10);
    reg_write = 1'b1; reg_dst = 1'b1; alu_result = 32'h0000_0010;
    tick();
    instruction = mk(0, 0, 11); alu_result = 32'h0000_0011;
    tick();
    reg_write = 1'b0; reg_dst = 1'b0;
    instruction = mk(10, 11, 0);
    #1;
    check("b2b_r10_byp", ifc_b.read_data_1, 32'h0000_0010);
    check("b2b_r10_nobyp", ifc_n.read_data_1, 32'h0000_0010);
    check("b2b_r11_byp", ifc_b.read_data_2, 32'h0000_0011);
    check("b2b_r11_nobyp_old", ifc_n.read_data_2, 32'h0);
    tick();
    check("b2b_r11_commit", ifc_n.read_data_2, 32'h0000_0011);

    // Load-use scoreboard on r9
    ld_issue = 1'b1; ld_dest = 5'd9;
    instruction = mk(9, 0, 0);
    #1;
    check("ld_pre_edge", ifc_b.hazard, 32'h0);
    tick();
    ld_issue = 1'b0;
    #1;
    check("ld_hazard_rs_byp", ifc_b.hazard, 32'h1);
    check("ld_hazard_rs_nobyp", ifc_n.hazard, 32'h1);
    instruction = mk(0, 9, 0);
    #1;
    check("ld_hazard_rt", ifc_b.hazard, 32'h1);
    instruction = mk(3, 4, 0);
    #1;
    check("ld_no_hazard_other", ifc_b.hazard, 32'h0);
    instruction = mk(0, 9, 0);
    reg_write = 1'b1; mem_to_reg = 1'b1;
    mem_data = 32'hCAFE_F00D; alu_result = 32'h0000_5555;
    tick();
    reg_write = 1'b0; mem_to_reg = 1'b0;
    instruction = mk(9, 0, 0);
    #1;
    check("ld_cleared", ifc_b.hazard, 32'h0);
    check("ld_wb_mem_data", ifc_b.wb_data, 32'hCAFE_F00D);
    check("ld_bypass_mem", ifc_b.read_data_1, 32'hCAFE_F00D);
    ld_issue = 1'b1; ld_dest = 5'd9;
    tick();
    ld_issue = 1'b0;
    #1;
    check("ld_reissue", ifc_b.hazard, 32'h1);
    instruction = mk(0, 9, 0);
    reg_write = 1'b1; mem_to_reg = 1'b1; mem_data = 32'h0000_0077;
    ld_issue = 1'b1; ld_dest = 5'd9;
    tick();
    reg_write = 1'b0; mem_to_reg = 1'b0; ld_issue = 1'b0;
    instruction = mk(9, 0, 0);
    #1;
    check("ld_set_wins_byp", ifc_b.hazard, 32'h1);
    check("ld_set_wins_nobyp", ifc_n.hazard, 32'h1);

    // Reset mid-cycle with a pending write to r5
    instruction = mk(0, 0, 5);
    reg_write = 1'b1; reg_dst = 1'b1; alu_result = 32'h0000_A5A5;
    tick();
    reg_write = 1'b0; reg_dst = 1'b0;
    instruction = mk(5, 9, 0);
    #1;
    check("rst_mid_wb_valid", ifc_b.wb_valid, 32'h1);
    check("rst_mid_wb_addr", ifc_b.wb_addr, 32'd5);
    #2 reset = 1'b0;
    #1;
    check("rst_async_wb_valid", ifc_b.wb_valid, 32'h0);
    check("rst_async_hazard", ifc_b.hazard, 32'h0);
    check("rst_async_wb_data", ifc_n.wb_data, 32'h0);
    check("rst_async_r9", ifc_b.read_data_2, 32'h0);
    @(posedge clock);
    #3 reset = 1'b1;
    tick();
    check("rst_r5_dropped_byp", ifc_b.read_data_1, 32'h0);
    check("rst_r5_dropped_nobyp", ifc_n.read_data_1, 32'h0);
    check("rst_busy_cleared", ifc_b.hazard, 32'h0);
    instruction = mk(29, 8, 0);
    #1;
    check("rst_sp_again", ifc_b.read_data_1, 32'h0000_7FFC);
    check("rst_r8_cleared", ifc_n.read_data_2, 32'h0);

    // Immediate extension
    instruction = {16'h0000, 16'h8001};
    zero_ext = 1'b0;
    #1;
    check("imm_sext_neg", ifc_b.imm_ext, 32'hFFFF_8001);
    zero_ext = 1'b1;
    #1;
    check("imm_zext", ifc_n.imm_ext, 32'h0000_8001);
    instruction = {16'h0000, 16'h7FFF};
    zero_ext = 1'b0;
    #1;
    check("imm_sext_pos", ifc_b.imm_ext, 32'h0000_7FFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
